// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: next-PC/redirect inputs, instruction-memory req/ack and decode valid/ready.
// master = fetch unit side, slave = memory/decode/next-PC side.
interface pc_fetch_unit_if #(
  parameter int unsigned MAX = 31
);
  logic [MAX:0] next_pc;
  logic         flush;
  logic         id_ready;
  logic         imem_req;
  logic [MAX:0] imem_addr;
  logic         imem_ack;
  logic [MAX:0] imem_rdata;
  logic         instr_valid;
  logic [MAX:0] instr;
  logic [MAX:0] pc_out;
  logic [MAX:0] pc_plus4;
  logic         pc_misalign;

  modport master (
    input  next_pc, flush, id_ready, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4, pc_misalign
  );

  modport slave (
    output next_pc, flush, id_ready, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4, pc_misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and req/ack instruction-fetch sequencer feeding decode over valid/ready.
// Optional feature macro: PC_ALIGN_CHECK_EN (force loaded PC to word alignment, sticky pc_misalign).
module pc_fetch_unit #(
  parameter int unsigned   MAX      = 31,
  parameter logic [MAX:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_unit_if.master  bus
);

  localparam int unsigned W = MAX + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [MAX:0] pc_q, pc_d;
  logic [MAX:0] pc_plus4_q, pc_plus4_d;
  logic [MAX:0] addr_q, addr_d;
  logic [MAX:0] instr_q, instr_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic         misalign_q, misalign_d;
  logic         load_c;
  logic [MAX:0] npc_c;
  logic         npc_bad_c;

`ifdef PC_ALIGN_CHECK_EN
  assign npc_c     = {bus.next_pc[MAX:2], 2'b00};
  assign npc_bad_c = |bus.next_pc[1:0];
`else
  assign npc_c     = bus.next_pc;
  assign npc_bad_c = 1'b0;
`endif

  // Next-state logic; load_c marks every cycle that samples next_pc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_q;
      end
      REQ: begin
        if (bus.flush) begin
          load_c = 1'b1;
          pc_d   = npc_c;
          if (bus.imem_ack) addr_d  = npc_c;
          else              state_d = DRAIN;
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (bus.flush) begin
          load_c = 1'b1;
          pc_d   = npc_c;
        end
        // Stale response is dropped; refetch from the (possibly just redirected) PC.
        if (bus.imem_ack) begin
          addr_d  = pc_d;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (bus.id_ready || bus.flush) begin
          load_c  = 1'b1;
          pc_d    = npc_c;
          addr_d  = npc_c;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    pc_plus4_d = pc_d + W'(4);
    req_d      = (state_d == REQ) || (state_d == DRAIN);
    valid_d    = (state_d == HOLD);
    misalign_d = misalign_q | (load_c & npc_bad_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + W'(4);
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios followed by a randomized run checked against a transaction-level PC/memory model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.MAX(31)) bus ();

  pc_fetch_unit #(.MAX(31), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    return {v[31:2], 2'b00};
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc, last_ack_addr, cur_addr, cur_instr, e;
  logic        cur_req, cur_valid, idle;
  int          deliveries;

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.id_ready = 1'b0; bus.imem_ack = 1'b0;
    bus.imem_rdata = '0; bus.next_pc = '0;

    // 1: reset and first fetch
    tick(); tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_misalign", bus.pc_misalign, 0);
    reset = 1'b0;
    tick();
    chk("t1_req", bus.imem_req, 1);
    chk("t1_addr", bus.imem_addr, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005;
    tick();
    bus.imem_ack = 1'b0;
    chk("t1_valid", bus.instr_valid, 1);
    chk("t1_instr", bus.instr, 32'h2008_0005);
    chk("t1_pc", bus.pc_out, 0);
    chk("t1_pc4", bus.pc_plus4, 4);
    chk("t1_req_low", bus.imem_req, 0);

    // 2: sequential stream with 0-cycle ack
    for (int i = 1; i <= 3; i++) begin
      bus.id_ready = 1'b1; bus.next_pc = 32'(4 * i);
      tick();
      bus.id_ready = 1'b0;
      chk("t2_req", bus.imem_req, 1);
      chk("t2_addr", bus.imem_addr, 32'(4 * i));
      chk("t2_valid_low", bus.instr_valid, 0);
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_f(32'(4 * i));
      tick();
      bus.imem_ack = 1'b0;
      chk("t2_valid", bus.instr_valid, 1);
      chk("t2_instr", bus.instr, mem_f(32'(4 * i)));
      chk("t2_pc", bus.pc_out, 32'(4 * i));
    end

    // 3: decode stalls in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid", bus.instr_valid, 1);
      chk("t3_instr", bus.instr, mem_f(32'hC));
      chk("t3_pc", bus.pc_out, 32'hC);
      chk("t3_req", bus.imem_req, 0);
    end

    // 4: redirect while the fetch at 8 is outstanding
    bus.id_ready = 1'b1; bus.next_pc = 32'h8;
    tick();
    bus.id_ready = 1'b0;
    chk("t4_addr8", bus.imem_addr, 32'h8);
    bus.flush = 1'b1; bus.next_pc = 32'h40;
    tick();
    bus.flush = 1'b0;
    chk("t4_drain_pc", bus.pc_out, 32'h40);
    for (int i = 0; i < 2; i++) begin
      chk("t4_drain_addr", bus.imem_addr, 32'h8);
      chk("t4_drain_req", bus.imem_req, 1);
      chk("t4_drain_valid", bus.instr_valid, 0);
      tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t4_refetch_addr", bus.imem_addr, 32'h40);
    chk("t4_refetch_req", bus.imem_req, 1);
    chk("t4_no_stale", bus.instr_valid, 0);
    bus.imem_rdata = mem_f(32'h40);
    tick();
    bus.imem_ack = 1'b0;
    chk("t4_valid", bus.instr_valid, 1);
    chk("t4_pc", bus.pc_out, 32'h40);
    chk("t4_instr", bus.instr, mem_f(32'h40));

    // 5: PC wrap, then reset mid-fetch
    bus.id_ready = 1'b1; bus.next_pc = 32'hFFFF_FFFC;
    tick();
    bus.id_ready = 1'b0;
    chk("t5_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", bus.pc_plus4, 32'h0);
    chk("t5_req", bus.imem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_req", bus.imem_req, 0);
    chk("t5_rst_valid", bus.instr_valid, 0);
    chk("t5_rst_pc", bus.pc_out, 0);

    // 6: misaligned next_pc
    tick();
    chk("t6_req", bus.imem_req, 1);
    chk("t6_addr", bus.imem_addr, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_f(0);
    tick();
    bus.imem_ack = 1'b0;
    bus.id_ready = 1'b1; bus.next_pc = 32'h102;
    tick();
    bus.id_ready = 1'b0;
    e = load_val(32'h102);
    chk("t6_pc", bus.pc_out, e);
    chk("t6_addr_load", bus.imem_addr, e);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_misalign", bus.pc_misalign, 1);
`else
    chk("t6_misalign", bus.pc_misalign, 0);
`endif
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_f(e);
    tick();
    bus.imem_ack = 1'b0;
    chk("t6_instr", bus.instr, mem_f(e));
    bus.id_ready = 1'b1; bus.next_pc = 32'h200;
    tick();
    bus.id_ready = 1'b0;
    chk("t6_pc2", bus.pc_out, 32'h200);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_sticky", bus.pc_misalign, 1);
`else
    chk("t6_sticky", bus.pc_misalign, 0);
`endif

    // Random run: model tracks only the architectural PC and the memory image
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_pc = 32'h0; last_ack_addr = 32'hFFFF_FFFF; idle = 1'b1; deliveries = 0;
    for (int k = 0; k < 1500; k++) begin
      cur_req   = bus.imem_req;
      cur_valid = bus.instr_valid;
      cur_addr  = bus.imem_addr;
      cur_instr = bus.instr;
      bus.imem_ack   = cur_req && ($urandom_range(0, 99) < 40);
      bus.imem_rdata = bus.imem_ack ? mem_f(cur_addr) : 32'($urandom);
      bus.id_ready   = cur_valid && ($urandom_range(0, 1) == 1);
      bus.flush      = ($urandom_range(0, 99) < 8);
      bus.next_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {30'($urandom), 2'b00};
      if (!idle && (bus.flush || bus.id_ready)) exp_pc = load_val(bus.next_pc);
      if (bus.imem_ack) last_ack_addr = cur_addr;
      tick();
      idle = 1'b0;
      chk("r_pc", bus.pc_out, exp_pc);
      chk("r_pc4", bus.pc_plus4, exp_pc + 32'd4);
      chk("r_excl", bus.imem_req & bus.instr_valid, 0);
      if (cur_req && !bus.imem_ack) begin
        chk("r_req_hold", bus.imem_req, 1);
        chk("r_addr_stable", bus.imem_addr, cur_addr);
      end
      if (bus.instr_valid && !cur_valid) begin
        deliveries++;
        chk("r_fetch_addr", last_ack_addr, exp_pc);
        chk("r_instr", bus.instr, mem_f(exp_pc));
      end
      if (cur_valid && !bus.id_ready && !bus.flush) begin
        chk("r_hold_valid", bus.instr_valid, 1);
        chk("r_hold_instr", bus.instr, cur_instr);
      end
      if (cur_valid && (bus.id_ready || bus.flush)) begin
        chk("r_accept_valid", bus.instr_valid, 0);
        chk("r_accept_req", bus.imem_req, 1);
        chk("r_accept_addr", bus.imem_addr, exp_pc);
      end
    end
    bus.imem_ack = 1'b0; bus.id_ready = 1'b0; bus.flush = 1'b0;
    chk("r_progress", 32'(deliveries > 100), 1);
    chk("r_misalign", bus.pc_misalign, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
